// File: rtl/instr_decode_stage.sv
// instr_decode_stage
//   Decode/issue stage in front of the register file and ALU. Accepts 32-bit
//   MIPS-style instructions over valid/ready. It decodes register addresses,
//   ALU op, shift count, immediate and the ALU-B mux select. The decoded beat
//   is held in an output register until the execute stage takes it.
//
//   Optional feature (macro HAZARD_STALL_EN):
//     defined   - in-flight writes are tracked and read-after-write hazards
//                 stall InstrReady.
//     undefined - no tracking; software must space dependent instructions.
//
//   Ports:
//     Clk, Rst_n          clock (rising edge), async active-low reset
//     InstrValid/Ready    upstream handshake, Instr = instruction word
//     DecValid/Ready      downstream handshake for the held decoded beat
//     RR1, RR2, WR, WE    register read/write addresses, write enable
//     AluOp, ShiftCount   ALU operation code and shift amount
//     Imm, UseImm         extended immediate, ALU B select (1 = Imm)
//     IllegalInstr        beat carries an undecodable instruction
module instr_decode_stage #(
  parameter int unsigned WB_LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        InstrValid,
  output logic        InstrReady,
  input  logic [31:0] Instr,
  output logic        DecValid,
  input  logic        DecReady,
  output logic [4:0]  RR1,
  output logic [4:0]  RR2,
  output logic [4:0]  WR,
  output logic        WE,
  output logic [3:0]  AluOp,
  output logic [4:0]  ShiftCount,
  output logic [31:0] Imm,
  output logic        UseImm,
  output logic        IllegalInstr
);

  if (WB_LATENCY < 1 || WB_LATENCY > 7) begin : g_bad_latency
    $error("instr_decode_stage: WB_LATENCY must be in 1..7");
  end

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_SRA = 6'h03;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef struct packed {
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [4:0]  wr;
    logic        we;
    logic [3:0]  alu_op;
    logic [4:0]  shift_count;
    logic [31:0] imm;
    logic        use_imm;
    logic        illegal;
  } beat_t;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm16;

  assign op    = Instr[31:26];
  assign rs    = Instr[25:21];
  assign rt    = Instr[20:16];
  assign rd    = Instr[15:11];
  assign shamt = Instr[10:6];
  assign funct = Instr[5:0];
  assign imm16 = Instr[15:0];

  beat_t dec_d;
  beat_t beat_q, beat_d;
  logic  dec_valid_q, dec_valid_d;
  logic  hazard;
  logic  instr_ready;
  logic  accept;
  logic  hand_off;

  // Illegal encodings keep the R-type field layout but never write.
  always_comb begin
    dec_d     = '0;
    dec_d.rr1 = rs;
    dec_d.rr2 = rt;
    dec_d.wr  = rd;
    dec_d.we  = 1'b1;
    if (op == OP_RTYPE) begin
      unique case (funct)
        F_ADD: dec_d.alu_op = 4'b0010;
        F_SUB: dec_d.alu_op = 4'b0110;
        F_AND: dec_d.alu_op = 4'b0000;
        F_OR:  dec_d.alu_op = 4'b0001;
        F_NOR: dec_d.alu_op = 4'b1100;
        F_SLT: dec_d.alu_op = 4'b0111;
        F_SLL, F_SRL, F_SRA: begin
          dec_d.alu_op      = (funct == F_SLL) ? 4'b1110 :
                              (funct == F_SRL) ? 4'b1101 : 4'b1111;
          dec_d.rr1         = rt;
          dec_d.shift_count = shamt;
        end
        default: begin
          dec_d.illegal = 1'b1;
          dec_d.we      = 1'b0;
        end
      endcase
    end else begin
      unique case (op)
        OP_ADDI, OP_SLTI: begin
          dec_d.alu_op  = (op == OP_ADDI) ? 4'b0010 : 4'b0111;
          dec_d.imm     = {{16{imm16[15]}}, imm16};
          dec_d.use_imm = 1'b1;
          dec_d.wr      = rt;
        end
        OP_ANDI, OP_ORI: begin
          dec_d.alu_op  = (op == OP_ANDI) ? 4'b0000 : 4'b0001;
          dec_d.imm     = {16'h0000, imm16};
          dec_d.use_imm = 1'b1;
          dec_d.wr      = rt;
        end
        default: begin
          dec_d.illegal = 1'b1;
          dec_d.we      = 1'b0;
        end
      endcase
    end
  end

  assign hand_off    = dec_valid_q && DecReady;
  assign instr_ready = (!dec_valid_q || DecReady) && !hazard;
  assign accept      = InstrValid && instr_ready;
  // Gated so every output reads zero while reset is held.
  assign InstrReady  = instr_ready && Rst_n;

  always_comb begin
    dec_valid_d = dec_valid_q;
    beat_d      = beat_q;
    if (accept) begin
      dec_valid_d = 1'b1;
      beat_d      = dec_d;
    end else if (hand_off) begin
      dec_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      dec_valid_q <= 1'b0;
      beat_q      <= '0;
    end else begin
      dec_valid_q <= dec_valid_d;
      beat_q      <= beat_d;
    end
  end

`ifdef HAZARD_STALL_EN
  // The last of the WB_LATENCY shift positions is not stored: a write that
  // retires on an edge is already visible to a reader accepted on that edge,
  // so only the first WB_LATENCY-1 positions can cause a stall.
  localparam int unsigned SB_DEPTH = (WB_LATENCY > 1) ? WB_LATENCY - 1 : 1;

  logic [SB_DEPTH-1:0] sb_valid_q, sb_valid_d;
  logic [4:0]          sb_addr_q [SB_DEPTH];
  logic [4:0]          sb_addr_d [SB_DEPTH];
  logic                use_rs, use_rt;

  // Shifts read only rt; immediates read only rs.
  always_comb begin
    use_rs = !(op == OP_RTYPE && (funct == F_SLL || funct == F_SRL || funct == F_SRA));
    use_rt = !dec_d.use_imm;
  end

  always_comb begin
    sb_valid_d    = '0;
    sb_addr_d     = sb_addr_q;
    sb_valid_d[0] = (WB_LATENCY > 1) && hand_off && beat_q.we;
    sb_addr_d[0]  = beat_q.wr;
    for (int unsigned i = 1; i < SB_DEPTH; i++) begin
      sb_valid_d[i] = sb_valid_q[i-1];
      sb_addr_d[i]  = sb_addr_q[i-1];
    end
  end

  // The held beat counts even in its hand-off cycle, so no gap opens.
  always_comb begin
    hazard = 1'b0;
    if (dec_valid_q && beat_q.we &&
        ((use_rs && rs == beat_q.wr) || (use_rt && rt == beat_q.wr)))
      hazard = 1'b1;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      if (sb_valid_q[i] &&
          ((use_rs && rs == sb_addr_q[i]) || (use_rt && rt == sb_addr_q[i])))
        hazard = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sb_valid_q <= '0;
      for (int unsigned i = 0; i < SB_DEPTH; i++) sb_addr_q[i] <= '0;
    end else begin
      sb_valid_q <= sb_valid_d;
      sb_addr_q  <= sb_addr_d;
    end
  end
`else
  assign hazard = 1'b0;
`endif

  assign DecValid     = dec_valid_q;
  assign RR1          = beat_q.rr1;
  assign RR2          = beat_q.rr2;
  assign WR           = beat_q.wr;
  assign WE           = beat_q.we;
  assign AluOp        = beat_q.alu_op;
  assign ShiftCount   = beat_q.shift_count;
  assign Imm          = beat_q.imm;
  assign UseImm       = beat_q.use_imm;
  assign IllegalInstr = beat_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage
//   Self-checking bench for instr_decode_stage: reference decoder, queue of
//   expected beats pushed on accept and compared/popped on hand-off, and a
//   per-register busy model predicting InstrReady.
module tb_instr_decode_stage;

  localparam int WB_LAT = 2;
`ifdef HAZARD_STALL_EN
  localparam bit HZ_EN = 1'b1;
`else
  localparam bit HZ_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instr;
  logic        DecValid;
  logic        DecReady;
  logic [4:0]  RR1, RR2, WR;
  logic        WE;
  logic [3:0]  AluOp;
  logic [4:0]  ShiftCount;
  logic [31:0] Imm;
  logic        UseImm;
  logic        IllegalInstr;

  instr_decode_stage #(.WB_LATENCY(WB_LAT)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .InstrValid(InstrValid), .InstrReady(InstrReady), .Instr(Instr),
    .DecValid(DecValid), .DecReady(DecReady),
    .RR1(RR1), .RR2(RR2), .WR(WR), .WE(WE), .AluOp(AluOp),
    .ShiftCount(ShiftCount), .Imm(Imm), .UseImm(UseImm),
    .IllegalInstr(IllegalInstr)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [4:0]  wr;
    logic        we;
    logic [3:0]  alu;
    logic [4:0]  sh;
    logic [31:0] imm;
    logic        use_imm;
    logic        ill;
    logic        use_rs;
    logic        use_rt;
  } beat_t;

  beat_t q[$];
  int    busy [32];
  int    edge_n   = 0;
  int    last_acc = 0;
  bit    acc_flag = 1'b0;
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic beat_t ref_decode(input logic [31:0] w);
    beat_t b;
    b        = '0;
    b.rr1    = w[25:21];
    b.rr2    = w[20:16];
    b.wr     = w[15:11];
    b.use_rs = 1'b1;
    b.use_rt = 1'b1;
    b.ill    = 1'b1;
    if (w[31:26] == 6'd0) begin
      case (w[5:0])
        6'h20: begin b.alu = 4'b0010; b.ill = 1'b0; end
        6'h22: begin b.alu = 4'b0110; b.ill = 1'b0; end
        6'h24: begin b.alu = 4'b0000; b.ill = 1'b0; end
        6'h25: begin b.alu = 4'b0001; b.ill = 1'b0; end
        6'h27: begin b.alu = 4'b1100; b.ill = 1'b0; end
        6'h2A: begin b.alu = 4'b0111; b.ill = 1'b0; end
        6'h00, 6'h02, 6'h03: begin
          b.alu    = (w[5:0] == 6'h00) ? 4'b1110 : (w[5:0] == 6'h02) ? 4'b1101 : 4'b1111;
          b.ill    = 1'b0;
          b.rr1    = w[20:16];
          b.sh     = w[10:6];
          b.use_rs = 1'b0;
        end
        default: ;
      endcase
    end else begin
      case (w[31:26])
        6'h08, 6'h0A, 6'h0C, 6'h0D: begin
          b.ill     = 1'b0;
          b.use_imm = 1'b1;
          b.use_rt  = 1'b0;
          b.wr      = w[20:16];
          case (w[31:26])
            6'h08:   b.alu = 4'b0010;
            6'h0A:   b.alu = 4'b0111;
            6'h0C:   b.alu = 4'b0000;
            default: b.alu = 4'b0001;
          endcase
          if (w[31:26] == 6'h08 || w[31:26] == 6'h0A) b.imm = $signed(w[15:0]);
          else                                         b.imm = {16'd0, w[15:0]};
        end
        default: ;
      endcase
    end
    b.we = !b.ill;
    return b;
  endfunction

  function automatic logic [63:0] pack(input beat_t b);
    return {5'd0, b.rr1, b.rr2, b.wr, b.we, b.alu, b.sh, b.imm, b.use_imm, b.ill};
  endfunction

  function automatic logic [63:0] dut_pack();
    return {5'd0, RR1, RR2, WR, WE, AluOp, ShiftCount, Imm, UseImm, IllegalInstr};
  endfunction

  function automatic bit src_busy(input logic [4:0] r);
    bit held;
    held = 1'b0;
    if (q.size() != 0) held = q[0].we && (q[0].wr == r);
    return held || (busy[r] > edge_n);
  endfunction

  function automatic bit mdl_hazard(input beat_t d, input logic [31:0] w);
    bit h;
    h = (d.use_rs && src_busy(w[25:21])) || (d.use_rt && src_busy(w[20:16]));
    return HZ_EN && h;
  endfunction

  // Called at a falling edge with inputs driven; returns at the next one.
  task automatic tick();
    beat_t d;
    bit    hz, exp_rdy, has_beat, ho;
    #1;
    d        = ref_decode(Instr);
    has_beat = (q.size() != 0);
    hz       = mdl_hazard(d, Instr);
    exp_rdy  = (!has_beat || DecReady) && !hz;
    check("instr_ready", 64'(InstrReady), 64'(exp_rdy));
    check("dec_valid", 64'(DecValid), 64'(has_beat));
    if (has_beat) check("beat", dut_pack(), pack(q[0]));
    acc_flag = InstrValid && exp_rdy;
    ho       = has_beat && DecReady;
    @(posedge Clk);
    if (ho) begin
      if (q[0].we) busy[q[0].wr] = edge_n + WB_LAT;
      void'(q.pop_front());
    end
    if (acc_flag) begin
      q.push_back(d);
      last_acc = edge_n;
    end
    edge_n++;
    @(negedge Clk);
  endtask

  task automatic drive(input logic iv, input logic [31:0] w, input logic dr);
    InstrValid = iv;
    Instr      = w;
    DecReady   = dr;
    tick();
  endtask

  task automatic send(input logic [31:0] w);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      drive(1'b1, w, 1'b1);
      done = acc_flag;
    end
    check("accepted", 64'(done), 64'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0]  fn;
    int unsigned k;
    w       = $urandom;
    w[25:21] = 5'($urandom_range(0, 7));
    w[20:16] = 5'($urandom_range(0, 7));
    w[15:11] = 5'($urandom_range(0, 7));
    k = $urandom_range(0, 9);
    case (k)
      5:       w[31:26] = 6'h08;
      6:       w[31:26] = 6'h0A;
      7:       w[31:26] = 6'h0C;
      8:       w[31:26] = 6'h0D;
      9:       w[31:26] = 6'h23;
      default: w[31:26] = 6'h00;
    endcase
    case ($urandom_range(0, 9))
      0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25; 4: fn = 6'h27;
      5: fn = 6'h2A; 6: fn = 6'h00; 7: fn = 6'h02; 8: fn = 6'h03;
      default: fn = 6'h21;
    endcase
    if (w[31:26] == 6'h00) w[5:0] = fn;
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a;
    foreach (busy[i]) busy[i] = 0;
    Rst_n      = 1'b0;
    InstrValid = 1'b0;
    Instr      = 32'h0;
    DecReady   = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("reset_valid", 64'(DecValid), 64'd0);
    check("reset_fields", dut_pack(), 64'd0);
    check("reset_ready", 64'(InstrReady), 64'd0);
    Rst_n = 1'b1;

    // add $3,$1,$2
    send(32'h00221820);
    check("add_fields", dut_pack(),
          {5'd0, 5'd1, 5'd2, 5'd3, 1'b1, 4'b0010, 5'd0, 32'd0, 1'b0, 1'b0});
    idle(4);
    // addi $5,$0,-2000 then ori $5,$0,0xF830
    send(32'h2005F830);
    check("addi_fields", dut_pack(),
          {5'd0, 5'd0, 5'd5, 5'd5, 1'b1, 4'b0010, 5'd0, 32'hFFFFF830, 1'b1, 1'b0});
    send(32'h3405F830);
    check("ori_fields", dut_pack(),
          {5'd0, 5'd0, 5'd5, 5'd5, 1'b1, 4'b0001, 5'd0, 32'h0000F830, 1'b1, 1'b0});
    idle(4);
    // sll $4,$1,2
    send(32'h00012080);
    check("sll_fields", dut_pack(),
          {5'd0, 5'd1, 5'd1, 5'd4, 1'b1, 4'b1110, 5'd2, 32'd0, 1'b0, 1'b0});
    idle(4);

    // add $3,$1,$2 then or $6,$3,$1 (RAW on $3)
    send(32'h00221820);
    a = last_acc;
    send(32'h00613025);
    check("raw_gap", 64'(last_acc - a), HZ_EN ? 64'(1 + WB_LAT) : 64'd1);
    idle(4);

    // Downstream stall with a pending independent instruction
    send(32'h00221820);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h00A63820, 1'b0);
      check("stall_no_accept", 64'(acc_flag), 64'd0);
    end
    drive(1'b1, 32'h00A63820, 1'b1);
    check("stall_release_accept", 64'(acc_flag), 64'd1);
    idle(4);

    // lw is illegal: no write, so a following reader of $0 is not stalled
    send(32'h8C220000);
    check("lw_fields", dut_pack(),
          {5'd0, 5'd1, 5'd2, 5'd0, 1'b0, 4'b0000, 5'd0, 32'd0, 1'b0, 1'b1});
    a = last_acc;
    send(32'h00003020);
    check("illegal_gap", 64'(last_acc - a), 64'd1);
    check("illegal_not_sticky", 64'(IllegalInstr), 64'd0);
    idle(4);

    // Reset during a stall
    send(32'h00221820);
    drive(1'b1, 32'h00A63820, 1'b0);
    Rst_n = 1'b0;
    #1;
    check("rst_async_valid", 64'(DecValid), 64'd0);
    check("rst_async_fields", dut_pack(), 64'd0);
    q.delete();
    foreach (busy[i]) busy[i] = 0;
    @(negedge Clk);
    Rst_n = 1'b1;
    drive(1'b1, 32'h00221820, 1'b1);
    check("post_rst_accept", 64'(acc_flag), 64'd1);
    idle(4);

    // Random mix with random back-pressure
    for (int i = 0; i < 300; i++)
      drive(($urandom_range(0, 3) != 0), rand_instr(), ($urandom_range(0, 3) != 0));
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
